// File: rtl/mem_bus_pkg.sv
// Shared bus definitions used by the CPU core and the memory/IO target.
package mem_bus_pkg;
  localparam logic [2:0] MNONE  = 3'b001;
  localparam logic [2:0] MREAD  = 3'b010;
  localparam logic [2:0] MWRITE = 3'b100;

  localparam logic [8:0] LED_ADDR_DFLT = 9'h100;
  localparam logic [8:0] SW_ADDR_DFLT  = 9'h140;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU <-> memory/IO bus: one-hot command, address, write data and read data.
interface mem_bus_ctrl_if #(parameter int AW = 9, parameter int DW = 16);
  logic [2:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output mem_cmd, mem_addr, wdata, input rdata);
  modport slave  (input mem_cmd, mem_addr, wdata, output rdata);
endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, read-first, registered read every cycle.
module ram_sp #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= din;
    dout <= r_mem[addr];
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory/IO bus target: RAM, LED register, switch port, post-reset RAM clear
// that holds the CPU in reset, and a sticky illegal-command flag.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int            AW             = 9,
  parameter int            DW             = 16,
  parameter logic [AW-1:0] LED_ADDR       = AW'(LED_ADDR_DFLT),
  parameter logic [AW-1:0] SW_ADDR        = AW'(SW_ADDR_DFLT),
  parameter bit            CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_ctrl_if.slave        bus,
  input  logic [7:0]           sw,
  output logic [7:0]           led,
  output logic                 cpu_reset,
  output logic                 init_done,
  output logic                 bus_err
);
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic          r_cpu_rst, r_init_done, r_bus_err, r_ram_pend;
  logic [7:0]    r_led;
  logic [DW-1:0] r_rdata;

  logic          w_run, w_rd, w_wr, w_bad, w_hit_led, w_hit_sw;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din, w_ram_dout;

  assign w_run     = (r_state == ST_RUN) && !reset;
  assign w_hit_led = (bus.mem_addr == LED_ADDR);
  assign w_hit_sw  = (bus.mem_addr == SW_ADDR);
  assign w_rd      = w_run && (bus.mem_cmd == MREAD);
  assign w_wr      = w_run && (bus.mem_cmd == MWRITE);
  assign w_bad     = w_run && (bus.mem_cmd != MNONE) && (bus.mem_cmd != MREAD)
                           && (bus.mem_cmd != MWRITE);

  always_ff @(posedge clk) r_state <= w_state_nxt;

  // Next state plus RAM port steering: the clear engine owns the port in INIT.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_addr  = bus.mem_addr;
    w_ram_din   = bus.wdata;
    if (reset) begin
      w_state_nxt = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    end else if (r_state == ST_INIT) begin
      w_ram_we   = 1'b1;
      w_ram_addr = r_clr_cnt;
      w_ram_din  = '0;
      if (r_clr_cnt == '1) w_state_nxt = ST_RUN;
    end else if (w_wr && !w_hit_led && !w_hit_sw) begin
      w_ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != ST_INIT) r_clr_cnt <= '0;
    else                             r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    r_cpu_rst   <= reset || (w_state_nxt != ST_RUN);
    r_init_done <= (w_state_nxt == ST_RUN);
  end

  // RAM reads land in the RAM's own output register; r_ram_pend selects it for
  // one cycle, after which the value is captured so rdata holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led      <= '0;
      r_bus_err  <= 1'b0;
      r_rdata    <= '0;
      r_ram_pend <= 1'b0;
    end else begin
      if (w_wr && w_hit_led) r_led <= bus.wdata[7:0];
      if (w_bad)             r_bus_err <= 1'b1;
      if (r_ram_pend)        r_rdata <= w_ram_dout;
      r_ram_pend <= w_rd && !w_hit_led && !w_hit_sw;
      if (w_rd && w_hit_sw)       r_rdata <= {{(DW-8){1'b0}}, sw};
      else if (w_rd && w_hit_led) r_rdata <= {{(DW-8){1'b0}}, r_led};
    end
  end

  ram_sp #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_dout)
  );

  assign bus.rdata = r_ram_pend ? w_ram_dout : r_rdata;
  assign led       = r_led;
  assign cpu_reset = r_cpu_rst;
  assign init_done = r_init_done;
  assign bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: clear/reset sequencing, directed vector table, and
// randomized traffic against a behavioural model.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw, led;
  logic       cpu_reset, init_done, bus_err;
  int         checks = 0, errors = 0;

  mem_bus_ctrl_if #(.AW(9), .DW(16)) bus ();

  mem_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sw        (sw),
    .led       (led),
    .cpu_reset (cpu_reset),
    .init_done (init_done),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [7:0]  sw;
    logic [15:0] e_rd;
    logic [7:0]  e_led;
    logic        e_err;
  } vec_t;

  vec_t vt[17];

  // behavioural model of the target's visible state
  logic [15:0] m_mem [512];
  logic [7:0]  m_led;
  logic        m_err;
  logic [15:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [8:0] a, input logic [15:0] w);
    bus.mem_cmd = c; bus.mem_addr = a; bus.wdata = w;
  endtask

  // Called at a negedge; holds reset across one rising edge.
  task automatic do_reset();
    drive(MNONE, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts cycles with cpu_reset high, starting with the current one.
  task automatic count_init(input string nm);
    int n = 0;
    while (cpu_reset === 1'b1 && n < 2000) begin
      if (init_done !== 1'b0) chk({nm, "_init_done_low"}, init_done, 1'b0);
      n++;
      @(negedge clk);
    end
    chk({nm, "_cpu_reset_cycles"}, n, 512);
    chk({nm, "_init_done_high"}, init_done, 1'b1);
    chk({nm, "_cpu_reset_low"}, cpu_reset, 1'b0);
  endtask

  task automatic preload_ff();
    for (int i = 0; i < 512; i++) dut.u_ram.r_mem[i] = 16'hFFFF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{MREAD,  9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0};
    vt[1]  = '{MREAD,  9'h0FF, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0};
    vt[2]  = '{MREAD,  9'h1FF, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0};
    vt[3]  = '{MWRITE, 9'h005, 16'hBEEF, 8'h00, 16'h0000, 8'h00, 1'b0};
    vt[4]  = '{MREAD,  9'h005, 16'h0000, 8'h00, 16'hBEEF, 8'h00, 1'b0};
    vt[5]  = '{MNONE,  9'h005, 16'h1111, 8'h00, 16'hBEEF, 8'h00, 1'b0};
    vt[6]  = '{MNONE,  9'h100, 16'h2222, 8'h00, 16'hBEEF, 8'h00, 1'b0};
    vt[7]  = '{MNONE,  9'h000, 16'h3333, 8'h00, 16'hBEEF, 8'h00, 1'b0};
    vt[8]  = '{MWRITE, 9'h100, 16'h12A5, 8'h00, 16'hBEEF, 8'hA5, 1'b0};
    vt[9]  = '{MREAD,  9'h100, 16'h0000, 8'h00, 16'h00A5, 8'hA5, 1'b0};
    vt[10] = '{MREAD,  9'h140, 16'h0000, 8'h3C, 16'h003C, 8'hA5, 1'b0};
    vt[11] = '{MWRITE, 9'h140, 16'h5555, 8'h3C, 16'h003C, 8'hA5, 1'b0};
    vt[12] = '{MREAD,  9'h005, 16'h0000, 8'h3C, 16'hBEEF, 8'hA5, 1'b0};
    vt[13] = '{3'b110, 9'h005, 16'h0000, 8'h3C, 16'hBEEF, 8'hA5, 1'b1};
    vt[14] = '{MNONE,  9'h005, 16'h0000, 8'h3C, 16'hBEEF, 8'hA5, 1'b1};
    vt[15] = '{MREAD,  9'h005, 16'h0000, 8'h3C, 16'hBEEF, 8'hA5, 1'b1};
    vt[16] = '{MREAD,  9'h140, 16'h0000, 8'h81, 16'h0081, 8'hA5, 1'b1};

    reset = 1'b0; sw = '0;
    drive(MNONE, '0, '0);
    @(negedge clk);
    preload_ff();

    // power-on reset and full clear
    do_reset();
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_bus_err",   bus_err,   1'b0);
    chk("rst_led",       led,       8'h00);
    chk("rst_rdata",     bus.rdata, 16'h0000);
    count_init("por");

    // directed vectors
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].cmd, vt[i].addr, vt[i].wd);
      sw = vt[i].sw;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].e_rd);
      chk($sformatf("vec%0d_led", i),   led,       vt[i].e_led);
      chk($sformatf("vec%0d_err", i),   bus_err,   vt[i].e_err);
    end
    chk("shadow_led_ram", dut.u_ram.r_mem[9'h100], 16'h0000);
    chk("shadow_sw_ram",  dut.u_ram.r_mem[9'h140], 16'h0000);

    // reset clears the sticky error and LED, then restart mid-clear
    do_reset();
    chk("rst2_bus_err",   bus_err,   1'b0);
    chk("rst2_led",       led,       8'h00);
    chk("rst2_rdata",     bus.rdata, 16'h0000);
    chk("rst2_cpu_reset", cpu_reset, 1'b1);
    repeat (200) @(negedge clk);
    chk("mid_cpu_reset", cpu_reset, 1'b1);
    chk("mid_clr_cnt",   dut.r_clr_cnt, 9'd200);
    preload_ff();
    do_reset();
    chk("restart_clr_cnt", dut.r_clr_cnt, 9'd0);
    count_init("restart");

    // randomized traffic against the model
    for (int i = 0; i < 512; i++) m_mem[i] = 16'h0000;
    m_led = 8'h00; m_err = 1'b0; m_rd = 16'h0000;
    for (int t = 0; t < 400; t++) begin
      logic [2:0]  c;
      logic [8:0]  a;
      logic [15:0] w;
      int r, ra;
      r = $urandom_range(0, 99);
      if      (r < 40) c = MREAD;
      else if (r < 80) c = MWRITE;
      else if (r < 98) c = MNONE;
      else begin
        logic [2:0] bad [5];
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        c = bad[$urandom_range(0, 4)];
      end
      ra = $urandom_range(0, 9);
      if      (ra == 0) a = 9'h100;
      else if (ra == 1) a = 9'h140;
      else if (ra == 9) a = 9'($urandom_range(0, 511));
      else              a = 9'($urandom_range(0, 15));
      w  = 16'($urandom);
      sw = 8'($urandom);
      case (c)
        MREAD: begin
          if      (a == 9'h140) m_rd = {8'h00, sw};
          else if (a == 9'h100) m_rd = {8'h00, m_led};
          else                  m_rd = m_mem[a];
        end
        MWRITE: begin
          if      (a == 9'h100) m_led = w[7:0];
          else if (a != 9'h140) m_mem[a] = w;
        end
        MNONE: ;
        default: m_err = 1'b1;
      endcase
      drive(c, a, w);
      @(negedge clk);
      chk($sformatf("rnd%0d_rdata", t), bus.rdata, m_rd);
      chk($sformatf("rnd%0d_led", t),   led,       m_led);
      chk($sformatf("rnd%0d_err", t),   bus_err,   m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
